// File: rtl/nanov_pkg.sv
// Shared types and constants for the nanoV bit-serial register-file scheduler.
package nanov_pkg;

  localparam int unsigned PHASE_W = 5;
  localparam int unsigned REG_W   = 32;
  localparam int unsigned ADDR_W  = 4;
  localparam logic [PHASE_W-1:0] LAST_PHASE = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CORE  = 2'd1,
    DEBUG = 2'd2
  } owner_t;

endpackage

// File: rtl/nanov_dbg_serdes.sv
// Debug-port word serialiser and deserialiser, both indexed by the rotation phase.
module nanov_dbg_serdes
  import nanov_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [PHASE_W-1:0] phase,
  input  logic [REG_W-1:0]   wdata,
  output logic               wbit,
  input  logic               capture_en,
  input  logic               zero_addr,
  input  logic               rbit,
  output logic [REG_W-1:0]   rdata
);

  logic [REG_W-1:0] shreg;
  logic [REG_W-1:0] captured;

  assign wbit = wdata[phase];

  // Merge the current bit so the final word is complete in the phase-31 cycle.
  always_comb begin
    captured        = shreg;
    captured[phase] = rbit;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg <= '0;
      rdata <= '0;
    end else if (capture_en) begin
      shreg <= captured;
      if (phase == LAST_PHASE) begin
        rdata <= zero_addr ? '0 : captured;
      end
    end
  end

endmodule

// File: rtl/nanov_reg_scheduler.sv
// Phase counter, window arbiter and register-file port mux for the nanoV serial register file.
module nanov_reg_scheduler
  import nanov_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               core_req,
  input  logic [ADDR_W-1:0]  core_rs1,
  input  logic [ADDR_W-1:0]  core_rs2,
  input  logic [ADDR_W-1:0]  core_rd,
  input  logic               core_wr_en,
  input  logic               core_wr_next_en,
  input  logic               core_data_rd,
  input  logic               core_data_rd_next,
  output logic               core_gnt,
  output logic               core_done,
  input  logic               dbg_req,
  input  logic [ADDR_W-1:0]  dbg_addr,
  input  logic               dbg_wr,
  input  logic [REG_W-1:0]   dbg_wdata,
  output logic               dbg_gnt,
  output logic               dbg_done,
  output logic [REG_W-1:0]   dbg_rdata,
  output logic [PHASE_W-1:0] phase,
  output logic [ADDR_W-1:0]  rf_rs1,
  output logic [ADDR_W-1:0]  rf_rs2,
  output logic [ADDR_W-1:0]  rf_rd,
  output logic               rf_wr_en,
  output logic               rf_wr_next_en,
  output logic               rf_read_through,
  output logic               rf_data_rd,
  output logic               rf_data_rd_next,
  input  logic               rf_data_rs1
);

  owner_t owner, owner_next;
  owner_t last_granted, last_next;
  logic   last_phase;
  logic   dbg_bit;

  assign last_phase = (phase == LAST_PHASE);
  assign core_gnt   = (owner == CORE);
  assign dbg_gnt    = (owner == DEBUG);
  assign core_done  = core_gnt && last_phase;
  assign dbg_done   = dbg_gnt && last_phase;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase        <= '0;
      owner        <= IDLE;
      last_granted <= DEBUG;
    end else begin
      phase        <= phase + 1'b1;
      owner        <= owner_next;
      last_granted <= last_next;
    end
  end

  // Ownership only moves on the window boundary; ties go to whoever was not granted last.
  always_comb begin
    owner_next = owner;
    last_next  = last_granted;
    if (last_phase) begin
      case ({core_req, dbg_req})
        2'b10:   owner_next = CORE;
        2'b01:   owner_next = DEBUG;
        2'b11:   owner_next = (last_granted == CORE) ? DEBUG : CORE;
        default: owner_next = IDLE;
      endcase
      if (owner_next != IDLE) begin
        last_next = owner_next;
      end
    end
  end

  nanov_dbg_serdes u_serdes (
    .clk        (clk),
    .rstn       (rstn),
    .phase      (phase),
    .wdata      (dbg_wdata),
    .wbit       (dbg_bit),
    .capture_en (dbg_gnt && !dbg_wr),
    .zero_addr  (dbg_addr == '0),
    .rbit       (rf_data_rs1),
    .rdata      (dbg_rdata)
  );

  always_comb begin
    rf_rs1          = '0;
    rf_rs2          = '0;
    rf_rd           = '0;
    rf_wr_en        = 1'b0;
    rf_wr_next_en   = 1'b0;
    rf_read_through = 1'b0;
    rf_data_rd      = 1'b0;
    rf_data_rd_next = 1'b0;
    case (owner)
      CORE: begin
        rf_rs1          = core_rs1;
        rf_rs2          = core_rs2;
        rf_rd           = core_rd;
        rf_wr_en        = core_wr_en;
        rf_wr_next_en   = core_wr_next_en;
        rf_read_through = core_wr_en | core_wr_next_en;
        rf_data_rd      = core_data_rd;
        rf_data_rd_next = core_data_rd_next;
      end
      DEBUG: begin
        rf_rs1          = dbg_addr;
        rf_rd           = dbg_addr;
        rf_wr_next_en   = dbg_wr && (dbg_addr != '0);
        rf_data_rd_next = dbg_bit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nanov_reg_scheduler.sv
// Self-checking bench: serial register-file environment plus a word-level reference model.
module tb_nanov_reg_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic        core_req;
  logic [3:0]  core_rs1, core_rs2, core_rd;
  logic        core_wr_en, core_wr_next_en, core_data_rd, core_data_rd_next;
  logic        core_gnt, core_done;
  logic        dbg_req;
  logic [3:0]  dbg_addr;
  logic        dbg_wr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_done;
  logic [31:0] dbg_rdata;
  logic [4:0]  phase;
  logic [3:0]  rf_rs1, rf_rs2, rf_rd;
  logic        rf_wr_en, rf_wr_next_en, rf_read_through, rf_data_rd, rf_data_rd_next;
  logic        rf_data_rs1;

  always #5 clk = ~clk;

  nanov_reg_scheduler dut (
    .clk(clk), .rstn(rstn),
    .core_req(core_req), .core_rs1(core_rs1), .core_rs2(core_rs2), .core_rd(core_rd),
    .core_wr_en(core_wr_en), .core_wr_next_en(core_wr_next_en),
    .core_data_rd(core_data_rd), .core_data_rd_next(core_data_rd_next),
    .core_gnt(core_gnt), .core_done(core_done),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wr(dbg_wr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .phase(phase), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_wr_en(rf_wr_en), .rf_wr_next_en(rf_wr_next_en), .rf_read_through(rf_read_through),
    .rf_data_rd(rf_data_rd), .rf_data_rd_next(rf_data_rd_next), .rf_data_rs1(rf_data_rs1)
  );

  // Bit-serial register file environment. x0 storage holds garbage so the scheduler's
  // own zero forcing for address 0 is exercised.
  logic [31:0] rf_mem [16];
  logic [31:0] seed   [16];
  logic        load_rf;
  logic [4:0]  tb_phase;

  always @(posedge clk) begin
    if (!rstn) tb_phase <= 5'd0;
    else       tb_phase <= tb_phase + 5'd1;
    if (load_rf) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= seed[i];
    end else if (rf_wr_next_en && rf_rd != 4'd0) begin
      rf_mem[rf_rd][tb_phase] <= rf_data_rd_next;
    end
  end

  assign rf_data_rs1 = rf_mem[rf_rs1][tb_phase];

  // Word-level reference model
  logic [31:0] model [16];
  bit          valid [16];
  logic [31:0] exp_rdata;
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    core_req = 0; core_rs1 = '0; core_rs2 = '0; core_rd = '0;
    core_wr_en = 0; core_wr_next_en = 0; core_data_rd = 0; core_data_rd_next = 0;
    dbg_req = 0; dbg_addr = '0; dbg_wr = 0; dbg_wdata = '0;
    repeat (3) tick();
    rstn = 1'b1;
    exp_rdata = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (phase !== 5'd0 || core_gnt !== 1'b0 || core_done !== 1'b0 || dbg_gnt !== 1'b0 ||
        dbg_done !== 1'b0 || dbg_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state phase=%0d cg=%b cd=%b dg=%b dd=%b rdata=%h (want all 0)",
               phase, core_gnt, core_done, dbg_gnt, dbg_done, dbg_rdata);
    end
    for (int i = 1; i <= 100; i++) begin
      core_rs1 = 4'($urandom); core_rs2 = 4'($urandom); core_rd = 4'($urandom);
      core_wr_en = 1'($urandom); core_wr_next_en = 1'($urandom);
      core_data_rd = 1'($urandom); core_data_rd_next = 1'($urandom);
      tick();
      checks++;
      if (phase !== 5'(i % 32)) begin
        errors++;
        $display("FAIL idle_phase cycle=%0d got=%0d want=%0d", i, phase, i % 32);
      end
      checks++;
      if ({rf_rs1, rf_rs2, rf_rd, rf_wr_en, rf_wr_next_en, rf_read_through, rf_data_rd,
           rf_data_rd_next, core_gnt, core_done, dbg_gnt, dbg_done} !== 20'd0) begin
        errors++;
        $display("FAIL idle_outputs cycle=%0d got rs1=%h rs2=%h rd=%h strobes=%b%b%b%b%b gnt/done=%b%b%b%b want 0",
                 i, rf_rs1, rf_rs2, rf_rd, rf_wr_en, rf_wr_next_en, rf_read_through,
                 rf_data_rd, rf_data_rd_next, core_gnt, core_done, dbg_gnt, dbg_done);
      end
    end
    core_rs1 = '0; core_rs2 = '0; core_rd = '0; core_wr_en = 0; core_wr_next_en = 0;
    core_data_rd = 0; core_data_rd_next = 0;
  endtask

  task automatic dbg_txn(input logic [3:0] addr, input logic wr, input logic [31:0] wdata);
    int unsigned cyc = 0, gnt_cycles = 0;
    bit done_seen = 0;
    dbg_addr = addr; dbg_wr = wr; dbg_wdata = wdata; dbg_req = 1'b1;
    while (!done_seen && cyc < 100) begin
      tick();
      cyc++;
      if (dbg_gnt) begin
        gnt_cycles++;
        checks++;
        if (rf_rs1 !== addr || rf_rs2 !== 4'd0 || rf_rd !== addr || rf_wr_en !== 1'b0 ||
            rf_read_through !== 1'b0 || rf_wr_next_en !== (wr && addr != 4'd0) ||
            rf_data_rd_next !== wdata[tb_phase]) begin
          errors++;
          $display("FAIL dbg_rf_drive addr=%0d wr=%b ph=%0d got rs1=%h rs2=%h rd=%h we=%b wne=%b rt=%b dn=%b want wne=%b dn=%b",
                   addr, wr, tb_phase, rf_rs1, rf_rs2, rf_rd, rf_wr_en, rf_wr_next_en,
                   rf_read_through, rf_data_rd_next, (wr && addr != 4'd0), wdata[tb_phase]);
        end
      end
      if (dbg_done) begin
        done_seen = 1;
        checks++;
        if (tb_phase !== 5'd31 || gnt_cycles != 32 || cyc > 64) begin
          errors++;
          $display("FAIL dbg_done_timing got phase=%0d gnt_cycles=%0d wait=%0d want 31/32/<=64",
                   tb_phase, gnt_cycles, cyc);
        end
      end
    end
    dbg_req = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL dbg_timeout got no dbg_done in %0d cycles want done", cyc);
    end
    tick();
    if (wr && addr != 4'd0) begin
      model[addr] = wdata;
      valid[addr] = 1;
    end
    if (!wr) exp_rdata = (addr == 4'd0) ? 32'd0 : model[addr];
    checks++;
    if (dbg_gnt !== 1'b0) begin
      errors++;
      $display("FAIL dbg_release got dbg_gnt=%b want 0", dbg_gnt);
    end
    checks++;
    if (dbg_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL dbg_rdata addr=%0d wr=%b got=%h want=%h", addr, wr, dbg_rdata, exp_rdata);
    end
  endtask

  task automatic core_txn(input logic [3:0] rd, input logic [31:0] word, input logic wr_next);
    int unsigned cyc = 0;
    bit done_seen = 0;
    core_req = 1'b1; core_rd = rd; core_wr_next_en = wr_next;
    core_rs1 = 4'($urandom); core_rs2 = 4'($urandom);
    while (!done_seen && cyc < 100) begin
      tick();
      cyc++;
      core_wr_en = 1'($urandom);
      core_data_rd = 1'($urandom);
      core_data_rd_next = word[tb_phase];
      #1;
      if (core_gnt) begin
        checks++;
        if (rf_rs1 !== core_rs1 || rf_rs2 !== core_rs2 || rf_rd !== rd ||
            rf_wr_en !== core_wr_en || rf_wr_next_en !== wr_next ||
            rf_read_through !== (core_wr_en | wr_next) || rf_data_rd !== core_data_rd ||
            rf_data_rd_next !== word[tb_phase] || dbg_gnt !== 1'b0) begin
          errors++;
          $display("FAIL core_pass ph=%0d got rs1=%h rs2=%h rd=%h we=%b wne=%b rt=%b d=%b dn=%b want %h %h %h %b %b %b %b %b",
                   tb_phase, rf_rs1, rf_rs2, rf_rd, rf_wr_en, rf_wr_next_en, rf_read_through,
                   rf_data_rd, rf_data_rd_next, core_rs1, core_rs2, rd, core_wr_en, wr_next,
                   core_wr_en | wr_next, core_data_rd, word[tb_phase]);
        end
      end
      if (core_done) begin
        done_seen = 1;
        checks++;
        if (tb_phase !== 5'd31 || core_gnt !== 1'b1 || cyc > 64) begin
          errors++;
          $display("FAIL core_done_timing got phase=%0d gnt=%b wait=%0d want 31/1/<=64",
                   tb_phase, core_gnt, cyc);
        end
      end
    end
    core_req = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL core_timeout got no core_done in %0d cycles want done", cyc);
    end
    tick();
    core_wr_next_en = 0; core_wr_en = 0;
    if (wr_next && rd != 4'd0) begin
      model[rd] = word;
      valid[rd] = 1;
    end
    checks++;
    if (core_gnt !== 1'b0 || rf_wr_next_en !== 1'b0) begin
      errors++;
      $display("FAIL core_release got gnt=%b wne=%b want 0/0", core_gnt, rf_wr_next_en);
    end
  endtask

  task automatic test_debug_rw();
    dbg_txn(4'd5, 1'b1, 32'hDEADBEEF);
    dbg_txn(4'd5, 1'b0, 32'h0);
    dbg_txn(4'd0, 1'b0, 32'h0);
  endtask

  task automatic test_x0_write();
    dbg_txn(4'd0, 1'b1, 32'hFFFFFFFF);
    dbg_txn(4'd5, 1'b0, 32'h0);
    dbg_txn(4'd0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int unsigned cyc = 0, last_cyc = 0, n = 0;
    do_reset();
    core_req = 1'b1; core_rs1 = 4'd2; core_rs2 = 4'd4; core_rd = 4'd6; core_wr_next_en = 0;
    dbg_req = 1'b1; dbg_addr = 4'd5; dbg_wr = 1'b0;
    while (n < 6 && cyc < 400) begin
      tick();
      cyc++;
      if (core_done || dbg_done) begin
        checks++;
        if (((n % 2) == 0) ? (core_done !== 1'b1 || dbg_done !== 1'b0)
                           : (dbg_done !== 1'b1 || core_done !== 1'b0)) begin
          errors++;
          $display("FAIL b2b_order window=%0d got core_done=%b dbg_done=%b want %s",
                   n, core_done, dbg_done, ((n % 2) == 0) ? "core" : "debug");
        end
        checks++;
        if ((n == 0) ? (cyc != 63) : (cyc - last_cyc != 32)) begin
          errors++;
          $display("FAIL b2b_spacing window=%0d got cycle=%0d prev=%0d want first=63 gap=32",
                   n, cyc, last_cyc);
        end
        last_cyc = cyc;
        n++;
      end
    end
    core_req = 1'b0; dbg_req = 1'b0;
    if (n < 6) begin
      checks++;
      errors++;
      $display("FAIL b2b_timeout got %0d windows want 6", n);
    end
    tick();
    exp_rdata = model[5];
    checks++;
    if (dbg_rdata !== exp_rdata || core_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got rdata=%h cg=%b dg=%b want %h/0/0", dbg_rdata, core_gnt, dbg_gnt, exp_rdata);
    end
  endtask

  task automatic test_core_write();
    logic [31:0] w;
    w = $urandom;
    core_txn(4'd3, w, 1'b1);
    dbg_txn(4'd3, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [3:0]  a;
      logic        wr;
      logic [31:0] w;
      a = 4'($urandom);
      wr = 1'($urandom);
      w = $urandom;
      if (!wr && !valid[a]) wr = 1'b1;
      if ($urandom_range(0, 2) == 0) core_txn(a, w, wr);
      else                           dbg_txn(a, wr, w);
    end
  endtask

  task automatic test_reset_mid_window();
    int unsigned cyc = 0;
    bit saw_done = 0;
    dbg_txn(4'd5, 1'b1, 32'hDEADBEEF);
    dbg_txn(4'd5, 1'b0, 32'h0);
    dbg_addr = 4'd7; dbg_wr = 1'b1; dbg_wdata = $urandom; dbg_req = 1'b1;
    while (!(dbg_gnt && tb_phase == 5'd12) && cyc < 100) begin
      tick();
      cyc++;
      if (dbg_done) saw_done = 1;
    end
    if (cyc >= 100) begin
      checks++;
      errors++;
      $display("FAIL abort_setup_timeout got no debug window in %0d cycles want grant", cyc);
    end
    rstn = 1'b0;
    tick();
    valid[7] = 0;
    exp_rdata = '0;
    checks++;
    if (saw_done || dbg_done !== 1'b0 || phase !== 5'd0 || dbg_gnt !== 1'b0 ||
        core_gnt !== 1'b0 || dbg_rdata !== 32'd0 || rf_wr_next_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got done=%b/%b phase=%0d dg=%b cg=%b rdata=%h wne=%b want 0/0/0/0/0/0/0",
               saw_done, dbg_done, phase, dbg_gnt, core_gnt, dbg_rdata, rf_wr_next_en);
    end
    rstn = 1'b1;
    dbg_req = 1'b0;
    dbg_txn(4'd7, 1'b1, 32'h1234_5678);
    dbg_txn(4'd7, 1'b0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      seed[i]  = $urandom;
      model[i] = seed[i];
      valid[i] = 1;
    end
    model[0] = '0;
    load_rf = 1'b1;
    rstn = 1'b0;
    tick();
    load_rf = 1'b0;
    test_reset();
    test_debug_rw();
    test_x0_write();
    test_back_to_back();
    test_core_write();
    test_random();
    test_reset_mid_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nanov_reg_scheduler.md
# nanov_reg_scheduler

Time-slot scheduler and arbiter for the nanoV bit-serial register file (15 × 32-bit, x0 = 0, one bit per clock, continuous rotation). It tracks the 32-cycle rotation phase and divides time into 32-cycle windows aligned to bit 0. At each window boundary it grants the register file to either the CPU core or a debug port. During debug windows it performs whole-register reads and writes by serialising and deserialising 32-bit words.

## Interface
Parameters:
- none; widths fixed by RV32E (`REG_W` = 32, `ADDR_W` = 4 in package).

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `core_req`  in  1  core wants the next window; held until `core_done`
- `core_rs1`, `core_rs2`, `core_rd`  in  4 each  core register indices, stable for whole window
- `core_wr_en`, `core_wr_next_en`  in  1 each  core write strobes (register-file semantics)
- `core_data_rd`, `core_data_rd_next`  in  1 each  core serial write data
- `core_gnt`  out  1  core owns current window
- `core_done`  out  1  one-cycle pulse on last cycle of a core window
- `dbg_req`  in  1  debug access request; held until `dbg_done`
- `dbg_addr`  in  4  debug register index
- `dbg_wr`  in  1  1 = write `dbg_wdata`, 0 = read
- `dbg_wdata`  in  32  write word
- `dbg_gnt`  out  1  debug owns current window
- `dbg_done`  out  1  one-cycle pulse on last cycle of a debug window
- `dbg_rdata`  out  32  read word; valid from the cycle after `dbg_done` until the next debug read completes
- `phase`  out  5  current bit index (0..31)
- `rf_rs1`, `rf_rs2`, `rf_rd`  out  4 each  register-file indices
- `rf_wr_en`, `rf_wr_next_en`, `rf_read_through`  out  1 each  register-file strobes
- `rf_data_rd`, `rf_data_rd_next`  out  1 each  register-file write data
- `rf_data_rs1`  in  1  register-file read bit (rs1 port)

## Operation
- `phase` is free-running: 0 after reset, +1 every clock, wraps 31→0. The rs port presents bit `phase` of the addressed register. Driving `rf_data_rd_next` with `rf_wr_next_en` at phase k writes bit k.
- Owner state is IDLE, CORE or DEBUG. It changes only on the clock edge leaving phase 31, from requests sampled at phase 31:
  - only `core_req` → CORE
  - only `dbg_req` → DEBUG
  - both → the owner not granted last; `last_granted` resets to DEBUG, so the core wins the first tie
  - neither → IDLE
- A request that is still high during its own window's phase 31 counts as a new request. The requester drops it in the cycle after done.
- CORE window:
  - all `core_*` register-file signals pass combinationally to `rf_*`
  - `rf_read_through` = `core_wr_en` | `core_wr_next_en`
- DEBUG window:
  - `rf_rs1` = `dbg_addr`, `rf_rs2` = 0, `rf_rd` = `dbg_addr`, `rf_wr_en` = 0, `rf_read_through` = 0
  - write: `rf_wr_next_en` = `dbg_wr` & (`dbg_addr` != 0); `rf_data_rd_next` = `dbg_wdata[phase]`
  - read: capture `rf_data_rs1` into shift register bit `phase` each cycle; copy to `dbg_rdata` at phase 31
  - address 0 reads 0; a write to address 0 is dropped, but the window still runs and `dbg_done` still pulses
- IDLE window: all `rf_*` outputs 0.
- `core_gnt`/`dbg_gnt` are high for exactly the 32 cycles of the owned window.

## Timing
- Reset values: `phase` = 0, owner IDLE, `gnt`/`done` = 0, `dbg_rdata` = 0, all `rf_*` = 0.
- The first possible grant starts at cycle 32 after reset release.
- Request-to-grant latency: 1–32 cycles, plus one window if the other requester wins the tie.
- `done` is asserted at phase 31; the next window starts at the following edge, giving back-to-back windows with no gap.
- Reset asserted mid-window:
  - window aborted, no `done` pulse
  - the target register's contents are undefined
  - `dbg_rdata` is cleared
- `rf_*` outputs are combinational from the owner register, `phase` and the port inputs; no added latency.

## Structure
- Package `nanov_pkg`:
  - owner enum {IDLE, CORE, DEBUG}
  - `PHASE_W` = 5, `LAST_PHASE` = 31, `REG_W` = 32, `ADDR_W` = 4
- Sub-module `nanov_dbg_serdes`: 32-bit parallel-to-serial mux plus serial-to-parallel capture, indexed by `phase`.
- Top level holds the phase counter, arbiter, owner register and output mux.

## Test plan
- Reset, no requests for 100 cycles → `phase` wraps 31→0, all `rf_*`, `gnt` and `done` stay 0.
- Debug write x5 = 0xDEADBEEF, then debug read x5 → `dbg_rdata` = 0xDEADBEEF after the second `dbg_done`; debug read x0 → 0.
- Debug write x0 = 0xFFFFFFFF → `rf_wr_next_en` stays 0 and `dbg_done` pulses; a subsequent read of x0 returns 0.
- `core_req` and `dbg_req` both held high continuously → windows alternate CORE, DEBUG, CORE, …, core first; each `done` is exactly 32 cycles apart.
- Core window with rd = 3 and `core_wr_next_en` → `rf_read_through` = 1 and signals pass through unchanged; a later debug read of x3 returns the serial word the core wrote.
- `rstn` low at phase 12 of a debug write → no `dbg_done`, `dbg_rdata` = 0, owner IDLE, `phase` = 0 on the next cycle.
